spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//   Synthesizable SPI master. It drives sck/mosi/csn and captures miso for one transfer
//   per start request. It supports all four CPOL/CPHA modes, 1..32-bit frames (MSB first)
//   and a programmable sck divider. It is the initiator counterpart of the testbench SPI
//   slave models and sits between a register/bus front end and the SPI pins.
// PARAMETERS
//   DIV_W   8   width of cfg_div; sck half-period = (cfg_div+1) clk cycles
// PORTS
//   clk        in   1       single clock; all logic on posedge
//   rst        in   1       synchronous, active-high reset
//   cfg_cpol   in   1       sck idle level
//   cfg_cpha   in   1       0: sample on leading edge; 1: sample on trailing edge
//   cfg_len    in   5       frame length minus one (N = cfg_len+1 bits)
//   cfg_div    in   DIV_W   half-period minus one (H = cfg_div+1 clk cycles)
//   start      in   1       transfer request; accepted only in IDLE
//   tx_data    in   32      transmit word; bits [N-1:0] sent, bit N-1 first
//   busy       out  1       high from the accept cycle+1 until done
//   done       out  1       one-cycle pulse at end of transfer
//   rx_data    out  32      received bits right-aligned in [N-1:0]; upper bits 0
//   sck        out  1       SPI clock
//   mosi       out  1       master out
//   miso       in   1       master in
//   csn        out  1       active-low chip select
// BEHAVIOUR
//   Reset values: csn=1, sck=0, mosi=0, busy=0, done=0, rx_data=0, FSM=IDLE, latched cfg=0.
//   All outputs are registered. A reset mid-transfer aborts it the next cycle with no done pulse.
//   FSM: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//     IDLE : csn=1, mosi=0, and sck <= cfg_cpol every cycle, so polarity settles before
//            csn falls. If start=1, latch cfg_*, tx_data and clear the shift-in register.
//            Next cycle: SETUP.
//     SETUP: csn=0, busy=1, mosi=tx[N-1]. Lasts H cycles, then XFER.
//     XFER : sck toggles every H cycles, 2N edges total. A leading edge goes from cpol to
//            ~cpol.
//            CPHA=0: shift miso in on each leading edge. On each trailing edge except the
//                    last, mosi advances to the next lower bit.
//            CPHA=1: on each leading edge, mosi drives the next bit (tx[N-1] first).
//                    Shift miso in on each trailing edge.
//            miso is sampled on the clk edge that registers the sampling sck edge.
//            After the 2N-th edge, sck = cpol. Then HOLD.
//     HOLD : csn stays 0 for H cycles, then csn=1 and go to GAP.
//     GAP  : csn=1 for H cycles (minimum deselect time). On exit, rx_data is loaded,
//            done=1 for that one cycle, busy=0, and the FSM enters IDLE.
//   busy stays high for exactly H*(2N+3) cycles per transfer.
//   start while busy is ignored, not queued. cfg_* and tx_data changes during a transfer
//   have no effect.
//   start in the same cycle done pulses is ignored; it is accepted from the next cycle on.
//   Bit and edge counters are sized for N=32 and H=2^DIV_W with no wrap.
//   cfg_len=31 gives a full 32-bit frame. cfg_div=0 gives sck = clk/2.
// TESTING
//   1) Assert rst 3 cycles with random inputs -> csn=1, sck=0, mosi=0, busy=0, done=0,
//      rx_data=0.
//   2) Mode 0, cfg_len=7, cfg_div=1, tx=0xA5, miso tied to mosi -> 8 rising sck edges,
//      busy high 38 cycles, one done pulse, rx_data=0x000000A5.
//   3) Modes 0..3, N=8, div=3, behavioural slave preloaded 0x3C, tx=0xC3 -> slave captures
//      0xC3, rx_data=0x3C, sck idles at CPOL before csn falls and after csn rises.
//   4) cfg_len=31, cfg_div=0, tx=0xDEADBEEF, loopback -> rx_data=0xDEADBEEF,
//      busy high 67 cycles.
//   5) Pulse start again and change cfg_*/tx_data mid-transfer -> waveform and rx_data match
//      the first request, exactly one done pulse.
//   6) rst at the 5th sck edge of an N=8 frame -> next cycle csn=1, sck=0, busy=0, no done;
//      a following mode-0 0x5A loopback returns 0x5A.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Bus-side bundle of the SPI master: configuration, start request,
// status and received word. Master = front end, slave = controller.
interface spi_master_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             cfg_cpol;
    logic             cfg_cpha;
    logic [4:0]       cfg_len;
    logic [DIV_W-1:0] cfg_div;
    logic             start;
    logic [31:0]      tx_data;
    logic             busy;
    logic             done;
    logic [31:0]      rx_data;

    modport master (
        output cfg_cpol,
        output cfg_cpha,
        output cfg_len,
        output cfg_div,
        output start,
        output tx_data,
        input  busy,
        input  done,
        input  rx_data
    );

    modport slave (
        input  cfg_cpol,
        input  cfg_cpha,
        input  cfg_len,
        input  cfg_div,
        input  start,
        input  tx_data,
        output busy,
        output done,
        output rx_data
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: one MSB-first frame of 1..32 bits per start request,
// all four CPOL/CPHA modes, sck half-period of cfg_div+1 clocks.
module spi_master_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_ctrl_if.slave bus,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             csn
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             cpol_q;
    logic             cpha_q;
    logic [4:0]       len_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [6:0]       edge_cnt;
    logic [31:0]      tx_sr;
    logic [31:0]      rx_sr;
    logic             busy_q;
    logic             done_q;
    logic [31:0]      rx_q;

    logic             tick;
    logic             lead_edge;
    logic             last_edge;
    logic             sample_now;
    logic             accept;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;

    // Half-period tick and classification of the sck edge about to be issued.
    always_comb begin
        tick       = (cnt == div_q);
        lead_edge  = ~edge_cnt[0];
        last_edge  = (edge_cnt == {1'b0, len_q, 1'b1});
        sample_now = lead_edge ^ cpha_q;
        accept     = bus.start & ~done_q;
    end

    // Transfer sequencer; every pin and status output is a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            csn      <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            len_q    <= '0;
            div_q    <= '0;
            cnt      <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // sck tracks the requested polarity so it is settled
                    // before csn falls.
                    sck      <= bus.cfg_cpol;
                    cnt      <= '0;
                    edge_cnt <= '0;
                    if (accept) begin
                        cpol_q <= bus.cfg_cpol;
                        cpha_q <= bus.cfg_cpha;
                        len_q  <= bus.cfg_len;
                        div_q  <= bus.cfg_div;
                        // Left-align the frame so the next bit is always [31].
                        tx_sr  <= bus.tx_data << (5'd31 - bus.cfg_len);
                        rx_sr  <= '0;
                        mosi   <= bus.tx_data[bus.cfg_len];
                        csn    <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SETUP;
                    end else begin
                        csn  <= 1'b1;
                        mosi <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                XFER: begin
                    if (tick) begin
                        cnt      <= '0;
                        edge_cnt <= edge_cnt + 7'd1;
                        sck      <= last_edge ? cpol_q : ~sck;
                        if (sample_now) begin
                            rx_sr <= {rx_sr[30:0], miso};
                        end
                        if (cpha_q && lead_edge) begin
                            mosi  <= tx_sr[31];
                            tx_sr <= tx_sr << 1;
                        end
                        // First bit is already on mosi from SETUP.
                        if (!cpha_q && !lead_edge && !last_edge) begin
                            mosi  <= tx_sr[30];
                            tx_sr <= tx_sr << 1;
                        end
                        if (last_edge) begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    sck <= cpol_q;
                    if (tick) begin
                        cnt   <= '0;
                        csn   <= 1'b1;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    sck <= cpol_q;
                    if (tick) begin
                        cnt    <= '0;
                        rx_q   <= rx_sr;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: loopback and a behavioural
// SPI slave, with a queue of expected received words.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck;
    logic mosi;
    logic miso;
    logic csn;

    spi_master_ctrl_if #(.DIV_W(8)) bus ();

    spi_master_ctrl #(.DIV_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso),
        .csn  (csn)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];

    logic        loopback = 1'b1;
    logic        t_cpol   = 1'b0;
    logic        t_cpha   = 1'b0;
    int          t_len    = 7;
    logic [31:0] slv_tx   = '0;
    logic [31:0] slv_rx   = '0;
    logic        slv_miso = 1'b0;
    int          slv_ptr  = 0;
    logic        p_sck    = 1'b0;
    logic        p_csn    = 1'b1;
    logic        lead;

    assign miso = loopback ? mosi : slv_miso;

    // Behavioural SPI slave following the configured mode.
    always @(sck or csn) begin
        if (p_csn === 1'b1 && csn === 1'b0) begin
            slv_rx  = '0;
            slv_ptr = t_len;
            if (!t_cpha) slv_miso = slv_tx[slv_ptr];
        end else if (csn === 1'b0 && sck !== p_sck) begin
            lead = (sck !== t_cpol);
            if (lead == !t_cpha) begin
                slv_rx = {slv_rx[30:0], mosi};
            end else if (t_cpha) begin
                if (slv_ptr >= 0) slv_miso = slv_tx[slv_ptr];
                slv_ptr--;
            end else begin
                slv_ptr--;
                if (slv_ptr >= 0) slv_miso = slv_tx[slv_ptr];
            end
        end
        p_sck = sck;
        p_csn = csn;
    end

    function automatic logic [31:0] len_mask(input logic [4:0] len);
        logic [32:0] m;
        m = (33'd1 << (len + 6'd1)) - 33'd1;
        return m[31:0];
    endfunction

    function automatic int busy_len(input logic [4:0] len, input logic [7:0] div);
        return (int'(div) + 1) * (2 * (int'(len) + 1) + 3);
    endfunction

    task automatic xfer(
        input  logic        cpol,
        input  logic        cpha,
        input  logic [4:0]  len,
        input  logic [7:0]  div,
        input  logic [31:0] tx,
        input  bit          disturb,
        output logic [31:0] got,
        output logic [31:0] exp_rx,
        output int          busy_cnt,
        output int          done_cnt,
        output int          rises,
        output bit          pre_ok,
        output bit          post_ok
    );
        logic prev;
        int   i;
        bit   seen;
        bus.cfg_cpol = cpol;
        bus.cfg_cpha = cpha;
        bus.cfg_len  = len;
        bus.cfg_div  = div;
        bus.tx_data  = tx;
        t_cpol   = cpol;
        t_cpha   = cpha;
        t_len    = int'(len);
        got      = '0;
        exp_rx   = '1;
        busy_cnt = 0;
        done_cnt = 0;
        rises    = 0;
        post_ok  = 1'b0;
        seen     = 1'b0;
        repeat (3) @(negedge clk);
        pre_ok = (sck === cpol) && (csn === 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        prev = sck;
        i = 0;
        while (!seen && i < 3000) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (sck === 1'b1 && prev === 1'b0) rises++;
            prev = sck;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                done_cnt++;
                got = bus.rx_data;
                if (exp_q.size() > 0) exp_rx = exp_q.pop_front();
                post_ok = (csn === 1'b1) && (sck === cpol);
            end
            if (disturb && i == 5) begin
                bus.start    = 1'b1;
                bus.cfg_cpol = ~cpol;
                bus.cfg_cpha = ~cpha;
                bus.cfg_len  = len - 5'd3;
                bus.cfg_div  = div + 8'd2;
                bus.tx_data  = ~tx;
            end
            if (disturb && i == 6) bus.start = 1'b0;
            i++;
            @(negedge clk);
        end
        repeat (4) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            bus.cfg_cpol = 1'($urandom_range(0, 1));
            bus.cfg_cpha = 1'($urandom_range(0, 1));
            bus.cfg_len  = 5'($urandom_range(0, 31));
            bus.cfg_div  = 8'($urandom_range(0, 255));
            bus.start    = 1'($urandom_range(0, 1));
            bus.tx_data  = $urandom;
            loopback     = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        n_total++;
        if (csn !== 1'b1) $display("FAIL reset_csn: got %b expected 1", csn);
        else n_pass++;
        n_total++;
        if (sck !== 1'b0) $display("FAIL reset_sck: got %b expected 0", sck);
        else n_pass++;
        n_total++;
        if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", mosi);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
        else n_pass++;
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
        else n_pass++;
        n_total++;
        if (bus.rx_data !== 32'h0) $display("FAIL reset_rx: got %h expected 0", bus.rx_data);
        else n_pass++;
        bus.start = 1'b0;
        loopback  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0;
        logic [31:0] got, exp_rx;
        int bc, dc, rc;
        bit pre, post;
        loopback = 1'b1;
        exp_q.push_back(32'hA5 & len_mask(5'd7));
        xfer(1'b0, 1'b0, 5'd7, 8'd1, 32'hA5, 1'b0, got, exp_rx, bc, dc, rc, pre, post);
        n_total++;
        if (got !== exp_rx) $display("FAIL mode0_rx: got %h expected %h", got, exp_rx);
        else n_pass++;
        n_total++;
        if (bc != 38) $display("FAIL mode0_busy: got %0d expected 38", bc);
        else n_pass++;
        n_total++;
        if (dc != 1) $display("FAIL mode0_done: got %0d expected 1", dc);
        else n_pass++;
        n_total++;
        if (rc != 8) $display("FAIL mode0_rises: got %0d expected 8", rc);
        else n_pass++;
    endtask

    task automatic test_modes;
        logic [31:0] got, exp_rx;
        int bc, dc, rc;
        bit pre, post;
        for (int m = 0; m < 4; m++) begin
            loopback = 1'b0;
            slv_tx   = 32'h3C;
            exp_q.push_back(32'h3C);
            xfer(m[1], m[0], 5'd7, 8'd3, 32'hC3, 1'b0, got, exp_rx, bc, dc, rc, pre, post);
            n_total++;
            if (got !== exp_rx) $display("FAIL mode%0d_rx: got %h expected %h", m, got, exp_rx);
            else n_pass++;
            n_total++;
            if (slv_rx !== 32'hC3) $display("FAIL mode%0d_slave: got %h expected c3", m, slv_rx);
            else n_pass++;
            n_total++;
            if (!pre) $display("FAIL mode%0d_idle_pre: got sck=%b expected %b", m, sck, m[1]);
            else n_pass++;
            n_total++;
            if (!post) $display("FAIL mode%0d_idle_post: got 0 expected 1", m);
            else n_pass++;
            n_total++;
            if (bc != busy_len(5'd7, 8'd3)) $display("FAIL mode%0d_busy: got %0d expected %0d", m, bc, busy_len(5'd7, 8'd3));
            else n_pass++;
        end
        loopback = 1'b1;
    endtask

    task automatic test_full_frame;
        logic [31:0] got, exp_rx;
        int bc, dc, rc;
        bit pre, post;
        loopback = 1'b1;
        exp_q.push_back(32'hDEADBEEF & len_mask(5'd31));
        xfer(1'b0, 1'b0, 5'd31, 8'd0, 32'hDEADBEEF, 1'b0, got, exp_rx, bc, dc, rc, pre, post);
        n_total++;
        if (got !== exp_rx) $display("FAIL full_rx: got %h expected %h", got, exp_rx);
        else n_pass++;
        n_total++;
        if (bc != 67) $display("FAIL full_busy: got %0d expected 67", bc);
        else n_pass++;
        n_total++;
        if (rc != 32) $display("FAIL full_rises: got %0d expected 32", rc);
        else n_pass++;
        loopback = 1'b1;
        exp_q.push_back(32'h1);
        xfer(1'b1, 1'b1, 5'd0, 8'd2, 32'hFFFF_FFFF, 1'b0, got, exp_rx, bc, dc, rc, pre, post);
        n_total++;
        if (got !== exp_rx) $display("FAIL one_bit_rx: got %h expected %h", got, exp_rx);
        else n_pass++;
        n_total++;
        if (bc != busy_len(5'd0, 8'd2)) $display("FAIL one_bit_busy: got %0d expected %0d", bc, busy_len(5'd0, 8'd2));
        else n_pass++;
    endtask

    task automatic test_ignore_midway;
        logic [31:0] got, exp_rx;
        int bc, dc, rc;
        bit pre, post;
        loopback = 1'b1;
        exp_q.push_back(32'h69);
        xfer(1'b0, 1'b0, 5'd7, 8'd1, 32'h69, 1'b1, got, exp_rx, bc, dc, rc, pre, post);
        n_total++;
        if (got !== exp_rx) $display("FAIL ignore_rx: got %h expected %h", got, exp_rx);
        else n_pass++;
        n_total++;
        if (dc != 1) $display("FAIL ignore_done: got %0d expected 1", dc);
        else n_pass++;
        n_total++;
        if (bc != 38) $display("FAIL ignore_busy: got %0d expected 38", bc);
        else n_pass++;
        n_total++;
        if (rc != 8) $display("FAIL ignore_rises: got %0d expected 8", rc);
        else n_pass++;
    endtask

    task automatic test_reset_midway;
        logic [31:0] got, exp_rx;
        int bc, dc, rc, edges, extra_done;
        bit pre, post, hit;
        logic prev;
        loopback     = 1'b1;
        bus.cfg_cpol = 1'b0;
        bus.cfg_cpha = 1'b0;
        bus.cfg_len  = 5'd7;
        bus.cfg_div  = 8'd1;
        bus.tx_data  = 32'h96;
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        t_len  = 7;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        prev  = sck;
        edges = 0;
        hit   = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (sck !== prev) edges++;
            prev = sck;
            if (edges == 5) begin
                hit = 1'b1;
                rst = 1'b1;
            end
            @(negedge clk);
        end
        n_total++;
        if (!hit) $display("FAIL rstmid_edge5: got %0d edges expected 5", edges);
        else n_pass++;
        n_total++;
        if (csn !== 1'b1) $display("FAIL rstmid_csn: got %b expected 1", csn);
        else n_pass++;
        n_total++;
        if (sck !== 1'b0) $display("FAIL rstmid_sck: got %b expected 0", sck);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy);
        else n_pass++;
        extra_done = (bus.done === 1'b1) ? 1 : 0;
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
        end
        n_total++;
        if (extra_done != 0) $display("FAIL rstmid_no_done: got %0d expected 0", extra_done);
        else n_pass++;
        exp_q.push_back(32'h5A);
        xfer(1'b0, 1'b0, 5'd7, 8'd1, 32'h5A, 1'b0, got, exp_rx, bc, dc, rc, pre, post);
        n_total++;
        if (got !== exp_rx) $display("FAIL rstmid_after_rx: got %h expected %h", got, exp_rx);
        else n_pass++;
        n_total++;
        if (dc != 1) $display("FAIL rstmid_after_done: got %0d expected 1", dc);
        else n_pass++;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.cfg_cpol = 1'b0;
        bus.cfg_cpha = 1'b0;
        bus.cfg_len  = '0;
        bus.cfg_div  = '0;
        bus.tx_data  = '0;
        test_reset();
        test_mode0();
        test_modes();
        test_full_frame();
        test_ignore_midway();
        test_reset_midway();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
